// File: rtl/vdic_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : vdic_frame_rx
// Purpose  : Serial frame receiver. Collects parity-checked data words into a
//            packet buffer and presents the packet on a valid/ready port when
//            a command word arrives.
// Revision : 1.0 - initial release
// ============================================================================
module vdic_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int MAX_WORDS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable_n,
    input  logic                              din,
    input  logic                              pkt_ready,
    output logic                              pkt_valid,
    output logic [DATA_W-1:0]                 pkt_cmd,
    output logic [MAX_WORDS*DATA_W-1:0]       pkt_data,
    output logic [$clog2(MAX_WORDS+1)-1:0]    pkt_count,
    output logic [2:0]                        pkt_err,
    output logic [7:0]                        drop_cnt
);

    localparam int CNT_W = $clog2(MAX_WORDS+1);
    localparam int BIT_W = $clog2(DATA_W+2);
    localparam logic [BIT_W-1:0] c_LAST_BIT  = BIT_W'(DATA_W+1);
    localparam logic [CNT_W-1:0] c_MAX_WORDS = CNT_W'(MAX_WORDS);
    localparam logic             c_PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                        r_state;
    logic [BIT_W-1:0]              r_bit_cnt;
    logic [DATA_W:0]               r_shift;
    logic [MAX_WORDS*DATA_W-1:0]   r_acc_data;
    logic [CNT_W-1:0]              r_acc_cnt;
    logic                          r_err_fr;
    logic                          r_err_ov;
    logic                          r_err_par;

    logic              w_last;
    logic              w_ctl;
    logic [DATA_W-1:0] w_data;
    logic              w_par_bad;
    logic              w_cmd_done;
    logic              w_room;
    logic              w_can_load;

    // r_shift holds {ctl, data} once the parity bit is on din
    assign w_last     = (r_state == S_SHIFT) && !enable_n && (r_bit_cnt == c_LAST_BIT);
    assign w_ctl      = r_shift[DATA_W];
    assign w_data     = r_shift[DATA_W-1:0];
    assign w_par_bad  = din != ((^w_data) ^ c_PAR_ODD);
    assign w_cmd_done = w_last && w_ctl;
    assign w_room     = r_acc_cnt < c_MAX_WORDS;
    assign w_can_load = !pkt_valid || pkt_ready;

    // Word deserializer and packet accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_acc_data <= '0;
            r_acc_cnt  <= '0;
            r_err_fr   <= 1'b0;
            r_err_ov   <= 1'b0;
            r_err_par  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!enable_n) begin
                        r_shift   <= {r_shift[DATA_W-1:0], din};
                        r_bit_cnt <= BIT_W'(1);
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (enable_n) begin
                        r_err_fr  <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else if (r_bit_cnt == c_LAST_BIT) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_IDLE;
                        if (w_ctl) begin
                            r_acc_data <= '0;
                            r_acc_cnt  <= '0;
                            r_err_fr   <= 1'b0;
                            r_err_ov   <= 1'b0;
                            r_err_par  <= 1'b0;
                        end else begin
                            r_err_par <= r_err_par | w_par_bad;
                            if (w_room) begin
                                for (int i = 0; i < MAX_WORDS; i++) begin
                                    if (r_acc_cnt == CNT_W'(i)) begin
                                        r_acc_data[i*DATA_W +: DATA_W] <= w_data;
                                    end
                                end
                                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                            end else begin
                                r_err_ov <= 1'b1;
                            end
                        end
                    end else begin
                        r_shift   <= {r_shift[DATA_W-1:0], din};
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    // Output packet register and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_valid <= 1'b0;
            pkt_cmd   <= '0;
            pkt_data  <= '0;
            pkt_count <= '0;
            pkt_err   <= '0;
            drop_cnt  <= '0;
        end else if (w_cmd_done && w_can_load) begin
            pkt_valid <= 1'b1;
            pkt_cmd   <= w_data;
            pkt_data  <= r_acc_data;
            pkt_count <= r_acc_cnt;
            pkt_err   <= {r_err_fr, r_err_ov, r_err_par | w_par_bad};
        end else if (w_cmd_done) begin
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (pkt_valid && pkt_ready) begin
            pkt_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vdic_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdic_frame_rx
// Purpose  : Directed self-checking bench for vdic_frame_rx (8-bit words,
//            8-word packets, even parity).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdic_frame_rx;

    logic        clk;
    logic        rst;
    logic        enable_n;
    logic        din;
    logic        pkt_ready;
    logic        pkt_valid;
    logic [7:0]  pkt_cmd;
    logic [63:0] pkt_data;
    logic [3:0]  pkt_count;
    logic [2:0]  pkt_err;
    logic [7:0]  drop_cnt;

    int vectors    = 0;
    int miscompares = 0;

    vdic_frame_rx #(
        .DATA_W     (8),
        .MAX_WORDS  (8),
        .PARITY_ODD (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable_n  (enable_n),
        .din       (din),
        .pkt_ready (pkt_ready),
        .pkt_valid (pkt_valid),
        .pkt_cmd   (pkt_cmd),
        .pkt_data  (pkt_data),
        .pkt_count (pkt_count),
        .pkt_err   (pkt_err),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] mkw(input logic ctl, input logic [7:0] d, input logic bad);
        return {ctl, d, (^d) ^ bad};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives w[hi] down to w[lo], one bit per clock; returns 1 time unit after the edge
    task automatic send_range(input logic [9:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            enable_n = 1'b0;
            din      = w[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [9:0] w);
        send_range(w, 9, 0);
    endtask

    task automatic idle(input int n);
        enable_n = 1'b1;
        din      = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; enable_n = 1'b1; din = 1'b0; pkt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(pkt_valid), 64'd0);
        chk("rst_data",  pkt_data,       64'd0);
        chk("rst_misc",  {pkt_cmd, pkt_count, pkt_err, drop_cnt}, 64'd0);
        rst = 1'b0;
        idle(1);

        // Two data words then a command; valid appears right after bit 30
        send_word(mkw(0, 8'h12, 0));
        send_word(mkw(0, 8'h34, 0));
        send_range(mkw(1, 8'h01, 0), 9, 1);
        chk("t1_valid_b29", 64'(pkt_valid), 64'd0);
        send_range(mkw(1, 8'h01, 0), 0, 0);
        chk("t1_valid_b30", 64'(pkt_valid), 64'd1);
        chk("t1_count", 64'(pkt_count), 64'd2);
        chk("t1_data",  pkt_data, 64'h3412);
        chk("t1_cmd",   64'(pkt_cmd), 64'h01);
        chk("t1_err",   64'(pkt_err), 64'b000);
        idle(1);
        chk("t1_xfer", 64'(pkt_valid), 64'd0);

        // Parity error on the data word
        send_word(mkw(0, 8'h0F, 1));
        send_word(mkw(1, 8'h02, 0));
        chk("t2_count", 64'(pkt_count), 64'd1);
        chk("t2_data",  pkt_data, 64'h0F);
        chk("t2_cmd",   64'(pkt_cmd), 64'h02);
        chk("t2_err",   64'(pkt_err), 64'b001);
        idle(1);

        // Nine data words: the ninth overflows
        for (int i = 1; i <= 9; i++) send_word(mkw(0, 8'(i), 0));
        send_word(mkw(1, 8'h04, 0));
        chk("t3_count", 64'(pkt_count), 64'd8);
        chk("t3_data",  pkt_data, 64'h0807060504030201);
        chk("t3_err",   64'(pkt_err), 64'b010);
        idle(1);

        // Truncated word then a clean one
        send_range(10'b0101000000, 9, 6);
        idle(2);
        send_word(mkw(0, 8'hAA, 0));
        send_word(mkw(1, 8'h05, 0));
        chk("t4_count", 64'(pkt_count), 64'd1);
        chk("t4_data",  pkt_data, 64'hAA);
        chk("t4_err",   64'(pkt_err), 64'b100);
        idle(1);

        // Backpressure: packet B is dropped while A is held
        pkt_ready = 1'b0;
        send_word(mkw(0, 8'h11, 0));
        send_word(mkw(1, 8'h0A, 0));
        chk("t5_a_valid", 64'(pkt_valid), 64'd1);
        send_word(mkw(0, 8'h22, 0));
        send_word(mkw(1, 8'h0B, 0));
        chk("t5_hold_cmd",  64'(pkt_cmd), 64'h0A);
        chk("t5_hold_data", pkt_data, 64'h11);
        chk("t5_hold_cnt",  64'(pkt_count), 64'd1);
        chk("t5_drop",      64'(drop_cnt), 64'd1);
        chk("t5_hold_vld",  64'(pkt_valid), 64'd1);
        pkt_ready = 1'b1;
        idle(1);
        chk("t5_a_xfer", 64'(pkt_valid), 64'd0);

        // Zero-word packet after a drop, then simultaneous transfer and reload
        pkt_ready = 1'b0;
        send_word(mkw(1, 8'h0C, 0));
        chk("t6_valid", 64'(pkt_valid), 64'd1);
        chk("t6_count", 64'(pkt_count), 64'd0);
        chk("t6_data",  pkt_data, 64'd0);
        chk("t6_cmd",   64'(pkt_cmd), 64'h0C);
        send_range(mkw(1, 8'h0D, 0), 9, 1);
        pkt_ready = 1'b1;
        send_range(mkw(1, 8'h0D, 0), 0, 0);
        chk("t6_reload_vld", 64'(pkt_valid), 64'd1);
        chk("t6_reload_cmd", 64'(pkt_cmd), 64'h0D);
        chk("t6_no_drop",    64'(drop_cnt), 64'd1);
        idle(1);
        chk("t6_xfer", 64'(pkt_valid), 64'd0);

        // Asynchronous reset in the middle of a word while a packet is held
        pkt_ready = 1'b0;
        send_word(mkw(1, 8'h0E, 0));
        send_range(mkw(0, 8'h77, 0), 9, 5);
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_valid", 64'(pkt_valid), 64'd0);
        chk("t7_rst_misc",  {pkt_cmd, pkt_count, pkt_err, drop_cnt}, 64'd0);
        chk("t7_rst_data",  pkt_data, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        pkt_ready = 1'b1;
        idle(1);
        send_word(mkw(0, 8'h55, 0));
        send_word(mkw(1, 8'h03, 0));
        chk("t7_count", 64'(pkt_count), 64'd1);
        chk("t7_data",  pkt_data, 64'h55);
        chk("t7_err",   64'(pkt_err), 64'b000);
        chk("t7_cmd",   64'(pkt_cmd), 64'h03);
        idle(1);

        // drop_cnt saturates: one load then 256 drops
        pkt_ready = 1'b0;
        for (int i = 0; i < 257; i++) send_word(mkw(1, 8'(i), 0));
        chk("t8_drop_sat", 64'(drop_cnt), 64'd255);
        chk("t8_hold_cmd", 64'(pkt_cmd), 64'h00);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
